// File: rtl/spad_arbiter.sv
// spad_arbiter: shares the single scratchpad port between the systolic array (M0)
// and the DMA/loader (M1). Read-address and write channels are arbitrated
// independently with round-robin priority. Outstanding reads are tracked in an
// in-order ID FIFO so that each returning R beat is steered back to the master
// that issued it.
module spad_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int RDATA_W   = 256,
    parameter int WDATA_W   = 256,
    parameter int MAX_OUTST = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,

    input  logic                         m0_ar_valid_i,
    output logic                         m0_ar_ready_o,
    input  logic [ADDR_W-1:0]            m0_ar_addr_i,
    output logic                         m0_r_valid_o,
    input  logic                         m0_r_ready_i,
    output logic [RDATA_W-1:0]           m0_r_data_o,
    input  logic                         m0_aw_valid_i,
    output logic                         m0_aw_ready_o,
    input  logic [ADDR_W-1:0]            m0_aw_addr_i,
    input  logic [WDATA_W-1:0]           m0_aw_data_i,

    input  logic                         m1_ar_valid_i,
    output logic                         m1_ar_ready_o,
    input  logic [ADDR_W-1:0]            m1_ar_addr_i,
    output logic                         m1_r_valid_o,
    input  logic                         m1_r_ready_i,
    output logic [RDATA_W-1:0]           m1_r_data_o,
    input  logic                         m1_aw_valid_i,
    output logic                         m1_aw_ready_o,
    input  logic [ADDR_W-1:0]            m1_aw_addr_i,
    input  logic [WDATA_W-1:0]           m1_aw_data_i,

    output logic                         s_ar_valid_o,
    input  logic                         s_ar_ready_i,
    output logic [ADDR_W-1:0]            s_ar_addr_o,
    input  logic                         s_r_valid_i,
    output logic                         s_r_ready_o,
    input  logic [RDATA_W-1:0]           s_r_data_i,
    output logic                         s_aw_valid_o,
    input  logic                         s_aw_ready_i,
    output logic [ADDR_W-1:0]            s_aw_addr_o,
    output logic [WDATA_W-1:0]           s_aw_data_o,

    output logic [$clog2(MAX_OUTST):0]   outst_cnt_o,
    output logic                         err_o
);

    localparam int PTR_W = $clog2(MAX_OUTST);
    localparam int CNT_W = PTR_W + 1;

    // Round-robin pointers (value = favoured master) and grant-lock state.
    logic                 rr_ar_q, rr_ar_d;
    logic                 ar_lock_q, ar_lock_d;
    logic                 ar_lock_id_q, ar_lock_id_d;
    logic                 rr_aw_q, rr_aw_d;
    logic                 aw_lock_q, aw_lock_d;
    logic                 aw_lock_id_q, aw_lock_id_d;

    // In-order ID FIFO of outstanding reads (one bit per entry: owning master).
    logic [MAX_OUTST-1:0] id_mem_q, id_mem_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic                 ar_grant;
    logic                 aw_grant;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 head_id;
    logic                 ar_xfer;
    logic                 aw_xfer;
    logic                 r_xfer;

    // Grant selection: a locked grant wins, otherwise the favoured requester, otherwise the other one.
    always_comb begin
        if (ar_lock_q) begin
            ar_grant = ar_lock_id_q;
        end else if (rr_ar_q ? m1_ar_valid_i : m0_ar_valid_i) begin
            ar_grant = rr_ar_q;
        end else begin
            ar_grant = ~rr_ar_q;
        end

        if (aw_lock_q) begin
            aw_grant = aw_lock_id_q;
        end else if (rr_aw_q ? m1_aw_valid_i : m0_aw_valid_i) begin
            aw_grant = rr_aw_q;
        end else begin
            aw_grant = ~rr_aw_q;
        end
    end

    assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTST));
    assign fifo_empty = (cnt_q == '0);
    assign head_id    = id_mem_q[rd_ptr_q];

    // AR channel: a full FIFO blocks new reads even if a pop happens this cycle.
    assign s_ar_valid_o  = (m0_ar_valid_i || m1_ar_valid_i) && !fifo_full;
    assign s_ar_addr_o   = ar_grant ? m1_ar_addr_i : m0_ar_addr_i;
    assign m0_ar_ready_o = s_ar_ready_i && !fifo_full && !ar_grant;
    assign m1_ar_ready_o = s_ar_ready_i && !fifo_full && ar_grant;
    assign ar_xfer       = s_ar_valid_o && s_ar_ready_i;

    // R channel: beats are steered to the FIFO head; beats with no owner are never accepted.
    assign m0_r_valid_o  = s_r_valid_i && !fifo_empty && !head_id;
    assign m1_r_valid_o  = s_r_valid_i && !fifo_empty && head_id;
    assign s_r_ready_o   = !fifo_empty && (head_id ? m1_r_ready_i : m0_r_ready_i);
    assign m0_r_data_o   = s_r_data_i;
    assign m1_r_data_o   = s_r_data_i;
    assign r_xfer        = s_r_valid_i && s_r_ready_o;

    // AW channel: writes carry no response, so no tracking beyond the grant.
    assign s_aw_valid_o  = m0_aw_valid_i || m1_aw_valid_i;
    assign s_aw_addr_o   = aw_grant ? m1_aw_addr_i : m0_aw_addr_i;
    assign s_aw_data_o   = aw_grant ? m1_aw_data_i : m0_aw_data_i;
    assign m0_aw_ready_o = s_aw_ready_i && !aw_grant;
    assign m1_aw_ready_o = s_aw_ready_i && aw_grant;
    assign aw_xfer       = s_aw_valid_o && s_aw_ready_i;

    assign outst_cnt_o   = cnt_q;
    assign err_o         = err_q;

    // Next-state: FIFO push/pop, round-robin update, grant locking while the slave stalls, sticky error.
    always_comb begin
        id_mem_d     = id_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        rr_ar_d      = rr_ar_q;
        ar_lock_d    = ar_lock_q;
        ar_lock_id_d = ar_lock_id_q;
        rr_aw_d      = rr_aw_q;
        aw_lock_d    = aw_lock_q;
        aw_lock_id_d = aw_lock_id_q;
        err_d        = err_q || (s_r_valid_i && fifo_empty);

        if (ar_xfer) begin
            id_mem_d[wr_ptr_q] = ar_grant;
            wr_ptr_d           = wr_ptr_q + 1'b1;
            rr_ar_d            = ~ar_grant;
            ar_lock_d          = 1'b0;
        end else if (s_ar_valid_o) begin
            ar_lock_d          = 1'b1;
            ar_lock_id_d       = ar_grant;
        end

        if (r_xfer) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({ar_xfer, r_xfer})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        if (aw_xfer) begin
            rr_aw_d      = ~aw_grant;
            aw_lock_d    = 1'b0;
        end else if (s_aw_valid_o) begin
            aw_lock_d    = 1'b1;
            aw_lock_id_d = aw_grant;
        end
    end

    // State registers; reset empties the FIFO, drops locks and favours M0 on both channels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_mem_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            rr_ar_q      <= 1'b0;
            ar_lock_q    <= 1'b0;
            ar_lock_id_q <= 1'b0;
            rr_aw_q      <= 1'b0;
            aw_lock_q    <= 1'b0;
            aw_lock_id_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            id_mem_q     <= id_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            rr_ar_q      <= rr_ar_d;
            ar_lock_q    <= ar_lock_d;
            ar_lock_id_q <= ar_lock_id_d;
            rr_aw_q      <= rr_aw_d;
            aw_lock_q    <= aw_lock_d;
            aw_lock_id_q <= aw_lock_id_d;
            err_q        <= err_d;
        end
    end

endmodule
